// File: rtl/io_bus_pkg.sv
// io_bus_pkg: FSM states, access size codes and exception codes shared by the bus initiator.
package io_bus_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] EXC_NONE    = 2'd0;
    localparam logic [1:0] EXC_ALIGN   = 2'd1;
    localparam logic [1:0] EXC_TIMEOUT = 2'd2;
    // Size code 3 behaves as a word, so any size with bit 1 set needs a word-aligned address
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        return (size == SZ_H && lo[0]) || (size[1] && lo != 2'd0);
    endfunction
endpackage

// File: rtl/io_bus_if.sv
// io_bus_if: peripheral register bus (word address, byte lanes, read strobe, write/read data, ready).
interface io_bus_if #(parameter int ADDR_W = 32);
    logic [ADDR_W-3:0] bus_addr;
    logic [3:0]        bus_byteEn;
    logic              bus_rd_en;
    logic [31:0]       bus_WD;
    logic [31:0]       bus_RD;
    logic              bus_ready;
    modport master (output bus_addr, bus_byteEn, bus_rd_en, bus_WD, input bus_RD, bus_ready);
    modport slave  (input bus_addr, bus_byteEn, bus_rd_en, bus_WD, output bus_RD, bus_ready);
endinterface

// File: rtl/io_lane_align.sv
// io_lane_align: maps access size and address offset to byte lanes, replicated write data and
// aligned, sign/zero-extended read data.
module io_lane_align
    import io_bus_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lo,
    input  logic        sgn,
    input  logic [31:0] wdata,
    input  logic [31:0] rd,
    output logic [3:0]  byte_en,
    output logic [31:0] wd,
    output logic [31:0] rdata
);
    logic [31:0] sh;
    assign sh = rd >> {lo, 3'b000};
    always_comb begin
        byte_en = size == SZ_B ? 4'b0001 << lo : size == SZ_H ? 4'b0011 << {lo[1], 1'b0} : 4'b1111;
        wd      = size == SZ_B ? {4{wdata[7:0]}} : size == SZ_H ? {2{wdata[15:0]}} : wdata;
        rdata   = size == SZ_B ? {{24{sgn & sh[7]}}, sh[7:0]} :
                  size == SZ_H ? {{16{sgn & sh[15]}}, sh[15:0]} : sh;
    end
endmodule

// File: rtl/io_bus_initiator.sv
// io_bus_initiator: turns one CPU load/store into a single peripheral bus transaction.
// Define BUS_TIMEOUT_EN to abort an ISSUE that sees no bus_ready for TIMEOUT_CYC cycles.
module io_bus_initiator
    import io_bus_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_signed,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_done,
    output logic [31:0]       cpu_rdata,
    output logic [1:0]        cpu_exc,
    io_bus_if.master          bus
);
    state_t            state, state_nxt;
    logic              we_q, sgn_q, tmo, misalign, issue, accept;
    logic [1:0]        size_q, exc_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, rdata_q, wd, rd_ext;
    logic [3:0]        be;

    io_lane_align u_align (
        .size    (size_q),
        .lo      (addr_q[1:0]),
        .sgn     (sgn_q),
        .wdata   (wdata_q),
        .rd      (bus.bus_RD),
        .byte_en (be),
        .wd      (wd),
        .rdata   (rd_ext)
    );

    assign misalign = misaligned(cpu_size, cpu_addr[1:0]);
    assign issue    = state == ISSUE;
    assign accept   = state == IDLE && cpu_req;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    logic [CNT_W-1:0] cnt;
    assign tmo = cnt == CNT_W'(TIMEOUT_CYC - 1);
    // Counts ISSUE cycles without ready; sits at zero outside ISSUE so every entry starts fresh
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= '0;
        else cnt <= issue && !bus.bus_ready ? cnt + 1'b1 : '0;
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt      = state == IDLE  ? (cpu_req ? (misalign ? DONE : ISSUE) : IDLE) :
                         state == ISSUE ? (bus.bus_ready || tmo ? DONE : ISSUE) : IDLE;
        cpu_stall      = reset & (accept | issue);
        cpu_done       = state == DONE;
        cpu_rdata      = cpu_done ? rdata_q : '0;
        cpu_exc        = cpu_done ? exc_q : EXC_NONE;
        bus.bus_addr   = issue ? addr_q[ADDR_W-1:2] : '0;
        bus.bus_byteEn = issue && we_q ? be : 4'b0000;
        bus.bus_rd_en  = issue && !we_q;
        bus.bus_WD     = issue && we_q ? wd : '0;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            we_q    <= 1'b0;
            sgn_q   <= 1'b0;
            size_q  <= SZ_B;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            exc_q   <= EXC_NONE;
        end else begin
            if (accept) begin
                we_q    <= cpu_we;
                sgn_q   <= cpu_signed;
                size_q  <= cpu_size;
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
                rdata_q <= '0;
                exc_q   <= misalign ? EXC_ALIGN : EXC_NONE;
            end
            if (issue && bus.bus_ready) rdata_q <= we_q ? '0 : rd_ext;
            else if (issue && tmo) exc_q <= EXC_TIMEOUT;
        end
endmodule

// File: tb/tb_io_bus_initiator.sv
// tb_io_bus_initiator: directed transactions checked every cycle against a byte-level access model.
// Honours BUS_TIMEOUT_EN the same way the design does.
module tb_io_bus_initiator;
    localparam int TIMEOUT_CYC = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_signed;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_stall, cpu_done;
    logic [31:0] cpu_rdata;
    logic [1:0]  cpu_exc;

    int checks = 0;
    int errors = 0;
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_done, exp_rd_en, exp_wd_chk;
    logic [31:0] exp_rdata, exp_wd;
    logic [1:0]  exp_exc;
    logic [29:0] exp_addr;
    logic [3:0]  exp_be;

    io_bus_if #(.ADDR_W(32)) bif ();

    io_bus_initiator #(.ADDR_W(32), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_size   (cpu_size),
        .cpu_signed (cpu_signed),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_done   (cpu_done),
        .cpu_rdata  (cpu_rdata),
        .cpu_exc    (cpu_exc),
        .bus        (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int nb(input logic [1:0] s);
        return s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
    endfunction

    function automatic logic [3:0] m_lanes(input logic [1:0] s, input logic [31:0] a);
        int off = int'(a[1:0]);
        int n = nb(s);
        logic [3:0] r = '0;
        for (int i = 0; i < 4; i++) r[i] = (i >= off) && (i < off + n);
        return r;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] s, input logic [31:0] w);
        int n = nb(s);
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_rd(input logic [1:0] s, input logic sg, input logic [31:0] a,
                                         input logic [31:0] rd);
        int off = int'(a[1:0]);
        int n = nb(s);
        longint v = 0;
        for (int j = 0; j < n; j++) v += longint'((rd >> (8*(off + j))) & 32'hFF) << (8*j);
        if (sg && n < 4 && v >= (longint'(1) << (8*n - 1))) v -= longint'(1) << (8*n);
        return v[31:0];
    endfunction

    task automatic set_idle();
        exp_stall = 0; exp_done = 0; exp_rdata = '0; exp_exc = 2'd0;
        exp_addr = '0; exp_be = '0; exp_rd_en = 0; exp_wd_chk = 1; exp_wd = '0;
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("cpu_stall", 32'(cpu_stall), 32'(exp_stall));
        chk("cpu_done", 32'(cpu_done), 32'(exp_done));
        chk("cpu_rdata", cpu_rdata, exp_rdata);
        chk("cpu_exc", 32'(cpu_exc), 32'(exp_exc));
        chk("bus_addr", 32'(bif.bus_addr), 32'(exp_addr));
        chk("bus_byteEn", 32'(bif.bus_byteEn), 32'(exp_be));
        chk("bus_rd_en", 32'(bif.bus_rd_en), 32'(exp_rd_en));
        if (exp_wd_chk) chk("bus_WD", bif.bus_WD, exp_wd);
    end

    task automatic do_txn(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int rdy_at, input int max_cyc);
        int n = nb(sz);
        logic mis = (int'(a[1:0]) % n) != 0;
        logic fin = 0;
        logic [1:0] e = 2'd0;
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = we; cpu_size = sz; cpu_signed = sg; cpu_addr = a; cpu_wdata = wd;
        bif.bus_ready = 0; bif.bus_RD = rd;
        set_idle(); exp_stall = 1;
        if (mis) begin
            @(posedge clk); #1;
            set_idle(); exp_done = 1; exp_exc = 2'd1;
        end else begin
            for (int k = 0; k < max_cyc && !fin; k++) begin
                @(posedge clk); #1;
                bif.bus_ready = k == rdy_at;
                set_idle(); exp_stall = 1; exp_addr = a[31:2];
                exp_be = we ? m_lanes(sz, a) : 4'b0000;
                exp_rd_en = !we; exp_wd_chk = we; exp_wd = m_wd(sz, wd);
                if (k == rdy_at) fin = 1;
`ifdef BUS_TIMEOUT_EN
                else if (k == TIMEOUT_CYC - 1) begin fin = 1; e = 2'd2; end
`endif
            end
            if (!fin) return;
            @(posedge clk); #1;
            bif.bus_ready = 0;
            set_idle(); exp_done = 1; exp_exc = e;
            exp_rdata = (we || e != 2'd0) ? 32'h0 : m_rd(sz, sg, a, rd);
        end
        @(posedge clk); #1;
        cpu_req = 0;
        set_idle();
    endtask

    task automatic abort_reset();
        @(posedge clk); #1;
        chk_en = 0;
        #2 reset = 0;
        #1;
        chk("rst cpu_stall", 32'(cpu_stall), 32'h0);
        chk("rst cpu_done", 32'(cpu_done), 32'h0);
        chk("rst cpu_rdata", cpu_rdata, 32'h0);
        chk("rst cpu_exc", 32'(cpu_exc), 32'h0);
        chk("rst bus_addr", 32'(bif.bus_addr), 32'h0);
        chk("rst bus_byteEn", 32'(bif.bus_byteEn), 32'h0);
        chk("rst bus_rd_en", 32'(bif.bus_rd_en), 32'h0);
        chk("rst bus_WD", bif.bus_WD, 32'h0);
        cpu_req = 0; bif.bus_ready = 0;
        set_idle();
        @(posedge clk); #1;
        reset = 1; chk_en = 1;
    endtask

    initial begin
        reset = 0; cpu_req = 0; cpu_we = 0; cpu_size = 0; cpu_signed = 0; cpu_addr = '0; cpu_wdata = '0;
        bif.bus_RD = '0; bif.bus_ready = 0;
        set_idle();
        repeat (2) @(posedge clk);
        #1 chk_en = 1;
        @(posedge clk); #1 reset = 1;

        chk("model lanes sb 7F12", 32'(m_lanes(2'd0, 32'h7F12)), 32'h4);
        chk("model lanes sh 7F16", 32'(m_lanes(2'd1, 32'h7F16)), 32'hC);
        chk("model wd sb", m_wd(2'd0, 32'h000000AB), 32'hABABABAB);
        chk("model wd sh", m_wd(2'd1, 32'h0000CAFE), 32'hCAFECAFE);
        chk("model lb", m_rd(2'd0, 1'b1, 32'h7F13, 32'h80FF0000), 32'hFFFFFF80);
        chk("model lhu", m_rd(2'd1, 1'b0, 32'h7F12, 32'hBEEF1234), 32'h0000BEEF);
        chk("model lh", m_rd(2'd1, 1'b1, 32'h7F12, 32'hBEEF1234), 32'hFFFFBEEF);

        do_txn(1, 2'd2, 0, 32'h7F10, 32'h12345678, 32'h0, 0, 50);
        do_txn(1, 2'd0, 0, 32'h7F12, 32'h000000AB, 32'h0, 0, 50);
        do_txn(0, 2'd0, 1, 32'h7F13, 32'h0, 32'h80FF0000, 0, 50);
        do_txn(0, 2'd1, 0, 32'h7F12, 32'h0, 32'hBEEF1234, 2, 50);
        do_txn(0, 2'd1, 1, 32'h7F12, 32'h0, 32'hBEEF1234, 0, 50);
        do_txn(0, 2'd2, 0, 32'h7F02, 32'h0, 32'h0, 0, 50);
        do_txn(1, 2'd1, 0, 32'h7F11, 32'h0000CAFE, 32'h0, 0, 50);
        do_txn(1, 2'd1, 0, 32'h7F16, 32'h0000CAFE, 32'h0, 3, 50);
        do_txn(0, 2'd3, 0, 32'h7F04, 32'h0, 32'hDEADBEEF, 1, 50);
        do_txn(0, 2'd0, 0, 32'h7F11, 32'h0, 32'h0000A500, 0, 50);
        do_txn(0, 2'd0, 1, 32'h7F10, 32'h0, 32'h0000007F, 0, 50);
`ifdef BUS_TIMEOUT_EN
        do_txn(1, 2'd2, 0, 32'h7F20, 32'h55AA55AA, 32'h0, -1, 200);
        do_txn(0, 2'd2, 0, 32'h7F24, 32'h0, 32'h13579BDF, -1, 200);
        do_txn(0, 2'd2, 0, 32'h7F24, 32'h0, 32'h13579BDF, TIMEOUT_CYC - 1, 200);
        do_txn(1, 2'd2, 0, 32'h7F28, 32'h0F0F0F0F, 32'h0, -1, 5);
        abort_reset();
`else
        do_txn(1, 2'd2, 0, 32'h7F20, 32'h55AA55AA, 32'h0, -1, 100);
        abort_reset();
`endif
        do_txn(1, 2'd2, 0, 32'h7F10, 32'h12345678, 32'h0, 0, 50);
        @(posedge clk); #1;
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
